// File: rtl/imsic_sched_pkg.sv
// Shared types and constants for the IMSIC MSI scheduler: delivery states,
// port selection and the interrupt-file numbering used by the decoders.
package imsic_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } sched_state_e;

    typedef enum logic {
        PORT_M = 1'b0,
        PORT_S = 1'b1
    } port_sel_e;

    localparam int unsigned FILE_M = 0;
    localparam int unsigned FILE_S = 1;
    localparam logic [11:0] SETIPNUM_LE_OFFSET = 12'h000;

endpackage

// File: rtl/imsic_msi_fifo.sv
// Small synchronous FIFO buffering decoded MSIs between arbitration and delivery.
// Full/empty come straight from the registered pointers (extra wrap bit).
module imsic_msi_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read once the pointers say so.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/imsic_msi_sched.sv
// Arbitrates the M and S/VS MSI write ports, validates targets and delivers
// buffered MSIs with a held valid. Define IMSIC_MSI_SCHED_FIXED_PRIO_EN for fixed M priority.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a buffered MSI
// HOLD  | o_msi_info_vld high, counting SETIP_KEEP_CYCLES
// GAP   | one low cycle between MSIs, may pop the next one
module imsic_msi_sched
    import imsic_sched_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH    = 32,
    parameter int NR_INTP_FILES     = 7,
    parameter int NR_HARTS          = 1,
    parameter int NR_SRC            = 256,
    parameter int SETIP_KEEP_CYCLES = 8,
    parameter int FIFO_DEPTH        = 4,
    localparam int NR_SRC_WIDTH     = $clog2(NR_SRC),
    localparam int NR_HARTS_WIDTH   = (NR_HARTS == 1) ? 1 : $clog2(NR_HARTS),
    localparam int INTP_FILE_WIDTH  = $clog2(NR_INTP_FILES),
    localparam int MSI_INFO_WIDTH   = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m_req_vld,
    input  logic [AXI_ADDR_WIDTH-1:0] m_req_addr,
    input  logic [31:0]               m_req_data,
    output logic                      m_req_rdy,
    input  logic                      s_req_vld,
    input  logic [AXI_ADDR_WIDTH-1:0] s_req_addr,
    input  logic [31:0]               s_req_data,
    output logic                      s_req_rdy,
    output logic                      o_addr_is_illegal,
    output logic [MSI_INFO_WIDTH-1:0] o_msi_info,
    output logic                      o_msi_info_vld,
    output logic                      o_busy
);

    localparam int CNT_WIDTH = (SETIP_KEEP_CYCLES > 1) ? $clog2(SETIP_KEEP_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(SETIP_KEEP_CYCLES - 1);

    sched_state_e              state_q, state_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [MSI_INFO_WIDTH-1:0] info_q, info_d;
    logic                      illegal_q, illegal_d;
    port_sel_e                 sel;
    logic                      xfer, legal;
    logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [MSI_INFO_WIDTH-1:0] fifo_dout, push_info;
    logic [11:0]               req_offset;
    logic [31:0]               req_data, hart_idx, file_idx;

`ifdef IMSIC_MSI_SCHED_FIXED_PRIO_EN
    always_comb begin
        sel = PORT_M;
        if (!m_req_vld && s_req_vld) begin
            sel = PORT_S;
        end
    end
`else
    port_sel_e rr_ptr_q, rr_ptr_d;

    always_comb begin
        sel = PORT_M;
        if (m_req_vld && s_req_vld) begin
            sel = rr_ptr_q;
        end else if (s_req_vld) begin
            sel = PORT_S;
        end
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = port_sel_e'(~rr_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= PORT_M;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Readiness looks only at the registered full flag, so nothing passes through when full.
    assign xfer      = (m_req_vld | s_req_vld) & ~fifo_full & ~rst;
    assign m_req_rdy = xfer & (sel == PORT_M);
    assign s_req_rdy = xfer & (sel == PORT_S);

    // Decode in 32-bit arithmetic so an out-of-range S file (g+1) is caught before truncation.
    always_comb begin
        req_offset = m_req_addr[11:0];
        req_data   = m_req_data;
        hart_idx   = 32'(m_req_addr[12 +: NR_HARTS_WIDTH]);
        file_idx   = FILE_M;
        if (sel == PORT_S) begin
            req_offset = s_req_addr[11:0];
            req_data   = s_req_data;
            hart_idx   = 32'(s_req_addr[12 + INTP_FILE_WIDTH +: NR_HARTS_WIDTH]);
            file_idx   = 32'(s_req_addr[12 +: INTP_FILE_WIDTH]) + FILE_S;
        end
        legal = (req_offset == SETIPNUM_LE_OFFSET) && (hart_idx < NR_HARTS) &&
                (file_idx < NR_INTP_FILES) && (req_data != 32'd0) && (req_data < NR_SRC);
        push_info = {hart_idx[NR_HARTS_WIDTH-1:0], file_idx[INTP_FILE_WIDTH-1:0],
                     req_data[NR_SRC_WIDTH-1:0]};
    end

    assign fifo_push = xfer & legal;
    assign illegal_d = xfer & ~legal;

    imsic_msi_fifo #(
        .WIDTH (MSI_INFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_info),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        info_d   = info_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE, GAP: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    info_d   = fifo_dout;
                    cnt_d    = '0;
                    state_d  = HOLD;
                end else begin
                    state_d  = IDLE;
                end
            end
            HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            info_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            info_q    <= info_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_msi_info        = info_q;
    assign o_msi_info_vld    = (state_q == HOLD);
    assign o_addr_is_illegal = illegal_q;
    assign o_busy            = ~fifo_empty | (state_q != IDLE);

endmodule

// File: tb/tb_imsic_msi_sched.sv
// Self-checking bench for imsic_msi_sched: directed scenarios plus random traffic,
// compared every cycle against a queue/timeline reference model.
module tb_imsic_msi_sched;

    localparam int KEEP  = 8;
    localparam int DEPTH = 4;
`ifdef IMSIC_MSI_SCHED_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_req_vld = 1'b0, s_req_vld = 1'b0;
    logic [31:0] m_req_addr = '0, s_req_addr = '0;
    logic [31:0] m_req_data = '0, s_req_data = '0;
    logic        m_req_rdy, s_req_rdy, o_addr_is_illegal, o_msi_info_vld, o_busy;
    logic [11:0] o_msi_info;

    always #5 clk = ~clk;

    imsic_msi_sched dut (
        .clk               (clk),
        .rst               (rst),
        .m_req_vld         (m_req_vld),
        .m_req_addr        (m_req_addr),
        .m_req_data        (m_req_data),
        .m_req_rdy         (m_req_rdy),
        .s_req_vld         (s_req_vld),
        .s_req_addr        (s_req_addr),
        .s_req_data        (s_req_data),
        .s_req_rdy         (s_req_rdy),
        .o_addr_is_illegal (o_addr_is_illegal),
        .o_msi_info        (o_msi_info),
        .o_msi_info_vld    (o_msi_info_vld),
        .o_busy            (o_busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    int   checks = 0;
    int   errors = 0;
    req_t m_q[$], s_q[$];

    // Reference model: buffered MSIs plus the cycle window of the current valid.
    int mdl_q[$];
    int rr, vld_start, vld_end, next_pop, last_info, cyc;
    bit ill_pend;

    int obs_info[$], obs_len[$], grant_log[$];
    int ill_seen, acc_count, run_len;
    bit prev_vld;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit req_legal(input bit is_s, input logic [31:0] a, input logic [31:0] d,
                                     output int info);
        int hart, file;
        if (is_s) begin
            file = int'((a >> 12) % 8) + 1;
            hart = int'((a >> 15) % 2);
        end else begin
            file = 0;
            hart = int'((a >> 12) % 2);
        end
        info = hart * 2048 + file * 256 + int'(d % 256);
        return (a % 4096 == 0) && (hart < 1) && (file < 7) && (d >= 1) && (d < 256);
    endfunction

    function automatic void model_reset();
        mdl_q.delete();
        rr        = 0;
        vld_start = -100;
        vld_end   = -100;
        next_pop  = 0;
        last_info = 0;
        ill_pend  = 1'b0;
    endfunction

    function automatic void clear_obs();
        obs_info.delete();
        obs_len.delete();
        grant_log.delete();
        ill_seen  = 0;
        acc_count = 0;
    endfunction

    function automatic req_t rand_req(input bit is_s);
        req_t r;
        int   k;
        k      = int'($urandom_range(0, 9));
        r.data = 32'($urandom_range(1, 255));
        r.addr = is_s ? 32'($urandom_range(0, 6)) << 12 : 32'd0;
        case (k)
            0: r.data = 32'd0;
            1: r.data = 32'd256 + 32'($urandom_range(0, 10));
            2: r.addr = r.addr | 32'($urandom_range(1, 4095));
            3: r.addr = 32'($urandom_range(0, 15)) << 12;
            default: ;
        endcase
        return r;
    endfunction

    task automatic step();
        bit mv, sv, full, exp_mr, exp_sr, legal;
        int sel, info;
        req_t r;
        mv = (m_q.size() > 0);
        sv = (s_q.size() > 0);
        m_req_vld = mv;
        s_req_vld = sv;
        if (mv) begin m_req_addr = m_q[0].addr; m_req_data = m_q[0].data; end
        if (sv) begin s_req_addr = s_q[0].addr; s_req_data = s_q[0].data; end
        #1;
        full   = (mdl_q.size() == DEPTH);
        sel    = (mv && sv) ? (FIXED ? 0 : rr) : (mv ? 0 : 1);
        exp_mr = !rst && !full && mv && (sel == 0);
        exp_sr = !rst && !full && sv && (sel == 1);
        check("m_rdy", m_req_rdy, exp_mr);
        check("s_rdy", s_req_rdy, exp_sr);
        check("vld", o_msi_info_vld, (cyc >= vld_start && cyc <= vld_end));
        check("info", o_msi_info, last_info);
        check("busy", o_busy, (mdl_q.size() != 0) || (cyc >= vld_start && cyc <= vld_end + 1));
        check("illegal", o_addr_is_illegal, ill_pend);

        if (m_req_rdy && m_req_vld) begin grant_log.push_back(0); acc_count++; end
        if (s_req_rdy && s_req_vld) begin grant_log.push_back(1); acc_count++; end
        if (o_addr_is_illegal) ill_seen++;
        if (o_msi_info_vld && !prev_vld) begin obs_info.push_back(int'(o_msi_info)); run_len = 0; end
        if (o_msi_info_vld) run_len++;
        if (!o_msi_info_vld && prev_vld) obs_len.push_back(run_len);
        prev_vld = o_msi_info_vld;

        if (rst) begin
            model_reset();
        end else begin
            if (mdl_q.size() > 0 && cyc >= next_pop) begin
                last_info = mdl_q.pop_front();
                vld_start = cyc + 1;
                vld_end   = cyc + KEEP;
                next_pop  = cyc + KEEP + 1;
            end
            ill_pend = 1'b0;
            if (exp_mr || exp_sr) begin
                r = exp_mr ? m_q.pop_front() : s_q.pop_front();
                legal = req_legal(exp_sr, r.addr, r.data, info);
                if (legal) mdl_q.push_back(info);
                ill_pend = !legal;
                rr ^= 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_idle(input int max_cycles);
        int n;
        n = 0;
        while ((m_q.size() > 0 || s_q.size() > 0 || mdl_q.size() > 0 || cyc <= vld_end + 1 || ill_pend)
               && n < max_cycles) begin
            step();
            n++;
        end
        step();
        if (n >= max_cycles) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout: observed %0d cycles required under %0d", n, max_cycles);
        end
    endtask

    initial begin
        model_reset();
        clear_obs();
        prev_vld = 1'b0;
        run_len  = 0;
        cyc      = 0;
        @(posedge clk);
        #1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Single M write
        clear_obs();
        m_q.push_back('{32'h0, 32'd5});
        run_idle(100);
        check("m_write_info", obs_info.size() > 0 ? obs_info[0] : -1, 32'h005);
        check("m_write_len", obs_len.size() > 0 ? obs_len[0] : -1, 32'd8);

        // S and VS writes
        clear_obs();
        s_q.push_back('{32'h0, 32'h20});
        s_q.push_back('{32'h1000, 32'h20});
        run_idle(100);
        check("s_write_info", obs_info.size() > 0 ? obs_info[0] : -1, 32'h120);
        check("vs_write_info", obs_info.size() > 1 ? obs_info[1] : -1, 32'h220);

        // Illegal requests
        clear_obs();
        s_q.push_back('{32'h6000, 32'h0});
        m_q.push_back('{32'h4, 32'd3});
        m_q.push_back('{32'h0, 32'd256});
        run_idle(100);
        check("illegal_pulses", ill_seen, 32'd3);
        check("illegal_no_msi", obs_info.size(), 32'd0);

        // Arbitration from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_obs();
        for (int i = 0; i < 3; i++) begin
            m_q.push_back('{32'h0, 32'(i + 1)});
            s_q.push_back('{32'h0, 32'(i + 8'h11)});
        end
        run_idle(200);
        check("arb_g0", grant_log.size() > 0 ? grant_log[0] : -1, 32'd0);
        check("arb_g1", grant_log.size() > 1 ? grant_log[1] : -1, FIXED ? 32'd0 : 32'd1);
        check("arb_g2", grant_log.size() > 2 ? grant_log[2] : -1, 32'd0);
        check("arb_g3", grant_log.size() > 3 ? grant_log[3] : -1, 32'd1);
        check("arb_msi_count", obs_info.size(), 32'd6);
        foreach (obs_len[i]) check("arb_len", obs_len[i], 32'd8);

        // FIFO full
        clear_obs();
        for (int i = 0; i < 6; i++) m_q.push_back('{32'h0, 32'(8'h31 + i)});
        repeat (6) step();
        check("full_accepted", acc_count, 32'd5);
        run_idle(200);
        check("full_msi_count", obs_info.size(), 32'd6);
        foreach (obs_info[i]) check("full_order", obs_info[i], 32'(8'h31 + i));

        // Reset in the middle of HOLD with more MSIs buffered
        for (int i = 0; i < 3; i++) m_q.push_back('{32'h0, 32'(8'h41 + i)});
        repeat (5) step();
        check("pre_rst_vld", o_msi_info_vld, 1'b1);
        m_q.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("post_rst_vld", o_msi_info_vld, 1'b0);
        check("post_rst_busy", o_busy, 1'b0);
        clear_obs();
        prev_vld = 1'b0;
        m_q.push_back('{32'h0, 32'h44});
        run_idle(100);
        check("post_rst_msi", obs_info.size() > 0 ? obs_info[0] : -1, 32'h044);

        // Random traffic on both ports
        for (int i = 0; i < 400; i++) begin
            if (m_q.size() < 2 && $urandom_range(0, 2) == 0) m_q.push_back(rand_req(1'b0));
            if (s_q.size() < 2 && $urandom_range(0, 2) == 0) s_q.push_back(rand_req(1'b1));
            step();
        end
        run_idle(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
